// File: rtl/e203_sram_arb_pkg.sv
// rtl/e203_sram_arb_pkg.sv - shared requester IDs for the SRAM ICB arbiter
package e203_sram_arb_pkg;

  typedef logic arb_id_t;

  localparam arb_id_t ID_CPU = 1'b0;
  localparam arb_id_t ID_ACC = 1'b1;

endpackage

// File: rtl/e203_sram_arb_idfifo.sv
// rtl/e203_sram_arb_idfifo.sv - outstanding-command ID FIFO (1-bit IDs, extra wrap bit pointers)
module e203_sram_arb_idfifo
  import e203_sram_arb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    push,
  input  arb_id_t push_id,
  input  logic    pop,
  output arb_id_t head_id,
  output logic    full,
  output logic    empty
);

  localparam int IW = $clog2(DEPTH);

  logic [IW:0] wptr;
  logic [IW:0] rptr;
  arb_id_t     mem [DEPTH];
  logic        push_en;
  logic        pop_en;

  // Pointers carry one extra wrap bit so full and empty are distinguishable
  assign full    = (wptr[IW] != rptr[IW]) && (wptr[IW-1:0] == rptr[IW-1:0]);
  assign empty   = (wptr == rptr);
  assign push_en = push & ~full;
  assign pop_en  = pop & ~empty;
  assign head_id = mem[rptr[IW-1:0]];

  // Pointer advance; reset empties the FIFO and drops anything in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push_en) wptr <= wptr + (IW+1)'(1);
      if (pop_en)  rptr <= rptr + (IW+1)'(1);
    end
  end

  // Storage write; contents are don't-care until a push covers them
  always_ff @(posedge clk) begin
    if (push_en) mem[wptr[IW-1:0]] <= push_id;
  end

endmodule

// File: rtl/e203_sram_icb_arb.sv
// rtl/e203_sram_icb_arb.sv - CPU/accelerator ICB arbiter for the shared SRAM (optional E203_SRAM_ARB_QOS_EN)
module e203_sram_icb_arb
  import e203_sram_arb_pkg::*;
#(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int OUTS_DEPTH = 4,
  parameter int STARVE_MAX = 16
) (
  input  logic            clk,
  input  logic            rst,
  // CPU port
  input  logic            c_icb_cmd_valid,
  output logic            c_icb_cmd_ready,
  input  logic            c_icb_cmd_read,
  input  logic [AW-1:0]   c_icb_cmd_addr,
  input  logic [DW-1:0]   c_icb_cmd_wdata,
  input  logic [DW/8-1:0] c_icb_cmd_wmask,
  output logic            c_icb_rsp_valid,
  input  logic            c_icb_rsp_ready,
  output logic            c_icb_rsp_err,
  output logic [DW-1:0]   c_icb_rsp_rdata,
  // Accelerator port
  input  logic            a_icb_cmd_valid,
  output logic            a_icb_cmd_ready,
  input  logic            a_icb_cmd_read,
  input  logic [AW-1:0]   a_icb_cmd_addr,
  input  logic [DW-1:0]   a_icb_cmd_wdata,
  input  logic [DW/8-1:0] a_icb_cmd_wmask,
  output logic            a_icb_rsp_valid,
  input  logic            a_icb_rsp_ready,
  output logic            a_icb_rsp_err,
  output logic [DW-1:0]   a_icb_rsp_rdata,
  // SRAM controller port
  output logic            o_icb_cmd_valid,
  input  logic            o_icb_cmd_ready,
  output logic            o_icb_cmd_read,
  output logic [AW-1:0]   o_icb_cmd_addr,
  output logic [DW-1:0]   o_icb_cmd_wdata,
  output logic [DW/8-1:0] o_icb_cmd_wmask,
  input  logic            o_icb_rsp_valid,
  output logic            o_icb_rsp_ready,
  input  logic            o_icb_rsp_err,
  input  logic [DW-1:0]   o_icb_rsp_rdata,
  output logic            busy
);

  // Reject unsupported configurations at elaboration
  if (OUTS_DEPTH < 2 || (OUTS_DEPTH & (OUTS_DEPTH - 1)) != 0 || STARVE_MAX < 1) begin : g_bad_cfg
    $error("e203_sram_icb_arb: OUTS_DEPTH must be a power of two >= 2 and STARVE_MAX >= 1");
  end

  logic    full;
  logic    empty;
  arb_id_t head_id;
  arb_id_t grant;
  logic    hold_vld;
  arb_id_t hold_id;
  logic    c_req;
  logic    a_req;
  logic    o_cmd_hs;
  logic    o_rsp_hs;
  logic    rsp_to_c;
  logic    rsp_to_a;

  assign c_req = c_icb_cmd_valid & ~full;
  assign a_req = a_icb_cmd_valid & ~full;

`ifdef E203_SRAM_ARB_QOS_EN
  localparam int SW = $clog2(STARVE_MAX + 1);

  logic [SW-1:0] starve_cnt;
  logic          starved;

  assign starved = (starve_cnt == SW'(STARVE_MAX));

  // CPU strict priority, except a starved accelerator or a frozen grant wins
  always_comb begin
    grant = ID_CPU;
    if (hold_vld)                  grant = hold_id;
    else if (a_req & (starved | ~c_req)) grant = ID_ACC;
    else                           grant = ID_CPU;
  end

  // Count cycles the accelerator waits; saturate at the limit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (~a_icb_cmd_valid | a_icb_cmd_ready) begin
      starve_cnt <= '0;
    end else if (~starved) begin
      starve_cnt <= starve_cnt + SW'(1);
    end
  end
`else
  arb_id_t last_id;

  // Round-robin: contention goes to whoever was not served last
  always_comb begin
    grant = ID_CPU;
    if (hold_vld)           grant = hold_id;
    else if (c_req & a_req) grant = ~last_id;
    else if (a_req)         grant = ID_ACC;
    else                    grant = ID_CPU;
  end

  // Remember the last served requester; reset favours the CPU
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           last_id <= ID_ACC;
    else if (o_cmd_hs) last_id <= grant;
  end
`endif

  // Command mux: payload of the granted requester, ready only back to it
  always_comb begin
    o_icb_cmd_valid = ((grant == ID_CPU) ? c_icb_cmd_valid : a_icb_cmd_valid) & ~full;
    o_icb_cmd_read  = (grant == ID_CPU) ? c_icb_cmd_read  : a_icb_cmd_read;
    o_icb_cmd_addr  = (grant == ID_CPU) ? c_icb_cmd_addr  : a_icb_cmd_addr;
    o_icb_cmd_wdata = (grant == ID_CPU) ? c_icb_cmd_wdata : a_icb_cmd_wdata;
    o_icb_cmd_wmask = (grant == ID_CPU) ? c_icb_cmd_wmask : a_icb_cmd_wmask;
    c_icb_cmd_ready = (grant == ID_CPU) & o_icb_cmd_ready & ~full;
    a_icb_cmd_ready = (grant == ID_ACC) & o_icb_cmd_ready & ~full;
  end

  assign o_cmd_hs = o_icb_cmd_valid & o_icb_cmd_ready;
  assign o_rsp_hs = o_icb_rsp_valid & o_icb_rsp_ready;

  // Freeze the grant while a presented command waits for ready
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_vld <= 1'b0;
      hold_id  <= ID_CPU;
    end else if (o_cmd_hs) begin
      hold_vld <= 1'b0;
    end else if (o_icb_cmd_valid) begin
      hold_vld <= 1'b1;
      hold_id  <= grant;
    end
  end

  e203_sram_arb_idfifo #(
    .DEPTH (OUTS_DEPTH)
  ) u_idfifo (
    .clk     (clk),
    .rst     (rst),
    .push    (o_cmd_hs),
    .push_id (grant),
    .pop     (o_rsp_hs),
    .head_id (head_id),
    .full    (full),
    .empty   (empty)
  );

  assign rsp_to_c = ~empty & (head_id == ID_CPU);
  assign rsp_to_a = ~empty & (head_id == ID_ACC);

  // Response steering to the owner of the oldest outstanding command
  always_comb begin
    c_icb_rsp_valid = o_icb_rsp_valid & rsp_to_c;
    a_icb_rsp_valid = o_icb_rsp_valid & rsp_to_a;
    c_icb_rsp_err   = o_icb_rsp_err & rsp_to_c;
    a_icb_rsp_err   = o_icb_rsp_err & rsp_to_a;
    c_icb_rsp_rdata = o_icb_rsp_rdata;
    a_icb_rsp_rdata = o_icb_rsp_rdata;
    o_icb_rsp_ready = (rsp_to_c & c_icb_rsp_ready) | (rsp_to_a & a_icb_rsp_ready);
  end

  assign busy = ~empty;

  // A response with nothing outstanding means the slave broke protocol
  a_no_orphan_rsp: assert property (@(posedge clk) disable iff (rst) !(o_icb_rsp_valid && empty));

  // A requester whose command is frozen must keep it valid
  a_held_valid: assert property (@(posedge clk) disable iff (rst)
    hold_vld |-> ((hold_id == ID_CPU) ? c_icb_cmd_valid : a_icb_cmd_valid));

endmodule

// File: tb/tb_e203_sram_icb_arb.sv
// tb/tb_e203_sram_icb_arb.sv - directed self-checking bench for e203_sram_icb_arb
module tb_e203_sram_icb_arb;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MW = DW / 8;
  localparam logic [AW-1:0] CA = 32'h4000_0100;
  localparam logic [AW-1:0] AA = 32'h4010_0200;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          c_icb_cmd_valid, c_icb_cmd_ready, c_icb_cmd_read;
  logic [AW-1:0] c_icb_cmd_addr;
  logic [DW-1:0] c_icb_cmd_wdata;
  logic [MW-1:0] c_icb_cmd_wmask;
  logic          c_icb_rsp_valid, c_icb_rsp_ready, c_icb_rsp_err;
  logic [DW-1:0] c_icb_rsp_rdata;
  logic          a_icb_cmd_valid, a_icb_cmd_ready, a_icb_cmd_read;
  logic [AW-1:0] a_icb_cmd_addr;
  logic [DW-1:0] a_icb_cmd_wdata;
  logic [MW-1:0] a_icb_cmd_wmask;
  logic          a_icb_rsp_valid, a_icb_rsp_ready, a_icb_rsp_err;
  logic [DW-1:0] a_icb_rsp_rdata;
  logic          o_icb_cmd_valid, o_icb_cmd_ready, o_icb_cmd_read;
  logic [AW-1:0] o_icb_cmd_addr;
  logic [DW-1:0] o_icb_cmd_wdata;
  logic [MW-1:0] o_icb_cmd_wmask;
  logic          o_icb_rsp_valid, o_icb_rsp_ready, o_icb_rsp_err;
  logic [DW-1:0] o_icb_rsp_rdata;
  logic          busy;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  e203_sram_icb_arb dut (
    .clk(clk), .rst(rst),
    .c_icb_cmd_valid(c_icb_cmd_valid), .c_icb_cmd_ready(c_icb_cmd_ready), .c_icb_cmd_read(c_icb_cmd_read),
    .c_icb_cmd_addr(c_icb_cmd_addr), .c_icb_cmd_wdata(c_icb_cmd_wdata), .c_icb_cmd_wmask(c_icb_cmd_wmask),
    .c_icb_rsp_valid(c_icb_rsp_valid), .c_icb_rsp_ready(c_icb_rsp_ready), .c_icb_rsp_err(c_icb_rsp_err),
    .c_icb_rsp_rdata(c_icb_rsp_rdata),
    .a_icb_cmd_valid(a_icb_cmd_valid), .a_icb_cmd_ready(a_icb_cmd_ready), .a_icb_cmd_read(a_icb_cmd_read),
    .a_icb_cmd_addr(a_icb_cmd_addr), .a_icb_cmd_wdata(a_icb_cmd_wdata), .a_icb_cmd_wmask(a_icb_cmd_wmask),
    .a_icb_rsp_valid(a_icb_rsp_valid), .a_icb_rsp_ready(a_icb_rsp_ready), .a_icb_rsp_err(a_icb_rsp_err),
    .a_icb_rsp_rdata(a_icb_rsp_rdata),
    .o_icb_cmd_valid(o_icb_cmd_valid), .o_icb_cmd_ready(o_icb_cmd_ready), .o_icb_cmd_read(o_icb_cmd_read),
    .o_icb_cmd_addr(o_icb_cmd_addr), .o_icb_cmd_wdata(o_icb_cmd_wdata), .o_icb_cmd_wmask(o_icb_cmd_wmask),
    .o_icb_rsp_valid(o_icb_rsp_valid), .o_icb_rsp_ready(o_icb_rsp_ready), .o_icb_rsp_err(o_icb_rsp_err),
    .o_icb_rsp_rdata(o_icb_rsp_rdata),
    .busy(busy)
  );

  task automatic idle_inputs();
    c_icb_cmd_valid = 1'b0; c_icb_cmd_read = 1'b1; c_icb_cmd_addr = CA;
    c_icb_cmd_wdata = '0;   c_icb_cmd_wmask = '0;  c_icb_rsp_ready = 1'b1;
    a_icb_cmd_valid = 1'b0; a_icb_cmd_read = 1'b1; a_icb_cmd_addr = AA;
    a_icb_cmd_wdata = '0;   a_icb_cmd_wmask = '0;  a_icb_rsp_ready = 1'b1;
    o_icb_cmd_ready = 1'b0; o_icb_rsp_valid = 1'b0; o_icb_rsp_err = 1'b0; o_icb_rsp_rdata = '0;
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b1;
    idle_inputs();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_cmp++; if (o_icb_cmd_valid !== 1'b0) begin n_err++; $display("FAIL reset_o_valid got=%b exp=0", o_icb_cmd_valid); end
    n_cmp++; if (c_icb_rsp_valid !== 1'b0 || a_icb_rsp_valid !== 1'b0) begin
      n_err++; $display("FAIL reset_rsp_valid got c=%b a=%b exp=0/0", c_icb_rsp_valid, a_icb_rsp_valid); end
    n_cmp++; if (o_icb_rsp_ready !== 1'b0) begin n_err++; $display("FAIL reset_o_rsp_ready got=%b exp=0", o_icb_rsp_ready); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single_read();
    c_icb_cmd_valid = 1'b1; c_icb_cmd_read = 1'b1; c_icb_cmd_addr = 32'h4000_0010; o_icb_cmd_ready = 1'b1;
    #1;
    n_cmp++; if (o_icb_cmd_valid !== 1'b1 || o_icb_cmd_addr !== 32'h4000_0010 || o_icb_cmd_read !== 1'b1) begin
      n_err++; $display("FAIL single_cmd got v=%b a=%h r=%b exp=1/40000010/1", o_icb_cmd_valid, o_icb_cmd_addr, o_icb_cmd_read); end
    n_cmp++; if (c_icb_cmd_ready !== 1'b1 || a_icb_cmd_ready !== 1'b0) begin
      n_err++; $display("FAIL single_ready got c=%b a=%b exp=1/0", c_icb_cmd_ready, a_icb_cmd_ready); end
    @(negedge clk);
    c_icb_cmd_valid = 1'b0; o_icb_cmd_ready = 1'b0;
    o_icb_rsp_valid = 1'b1; o_icb_rsp_rdata = 32'h1234_5678;
    #1;
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL single_busy got=%b exp=1", busy); end
    n_cmp++; if (c_icb_rsp_valid !== 1'b1 || c_icb_rsp_rdata !== 32'h1234_5678 || a_icb_rsp_valid !== 1'b0) begin
      n_err++; $display("FAIL single_rsp got cv=%b d=%h av=%b exp=1/12345678/0", c_icb_rsp_valid, c_icb_rsp_rdata, a_icb_rsp_valid); end
    n_cmp++; if (o_icb_rsp_ready !== 1'b1) begin n_err++; $display("FAIL single_o_rsp_ready got=%b exp=1", o_icb_rsp_ready); end
    @(negedge clk);
    o_icb_rsp_valid = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL single_idle_busy got=%b exp=0", busy); end
  endtask

  task automatic test_round_robin();
    reset_dut();
    c_icb_cmd_valid = 1'b1; a_icb_cmd_valid = 1'b1; o_icb_cmd_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      o_icb_rsp_valid = (i > 0);
      o_icb_rsp_rdata = 32'(i);
      #1;
      n_cmp++; if (o_icb_cmd_addr !== ((i % 2) ? AA : CA) || c_icb_cmd_ready !== ((i % 2) == 0)) begin
        n_err++; $display("FAIL rr_grant cyc=%0d got addr=%h cr=%b exp addr=%h", i, o_icb_cmd_addr, c_icb_cmd_ready, (i % 2) ? AA : CA); end
      if (i > 0) begin
        n_cmp++; if (c_icb_rsp_valid !== (((i - 1) % 2) == 0) || a_icb_rsp_valid !== (((i - 1) % 2) == 1)) begin
          n_err++; $display("FAIL rr_rsp cyc=%0d got c=%b a=%b exp c=%b", i, c_icb_rsp_valid, a_icb_rsp_valid, ((i - 1) % 2) == 0); end
      end
      @(negedge clk);
    end
    c_icb_cmd_valid = 1'b0; a_icb_cmd_valid = 1'b0; o_icb_rsp_valid = 1'b1;
    #1;
    n_cmp++; if (a_icb_rsp_valid !== 1'b1) begin n_err++; $display("FAIL rr_last_rsp got a=%b exp=1", a_icb_rsp_valid); end
    @(negedge clk);
    o_icb_rsp_valid = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rr_drain_busy got=%b exp=0", busy); end
  endtask

  task automatic test_hold();
    reset_dut();
    a_icb_cmd_valid = 1'b1; o_icb_cmd_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i == 1) c_icb_cmd_valid = 1'b1;
      #1;
      n_cmp++; if (o_icb_cmd_valid !== 1'b1 || o_icb_cmd_addr !== AA || c_icb_cmd_ready !== 1'b0 ||
                   a_icb_cmd_ready !== 1'b0 || busy !== 1'b0) begin
        n_err++; $display("FAIL hold_stable cyc=%0d got v=%b addr=%h cr=%b ar=%b busy=%b exp 1/%h/0/0/0",
                          i, o_icb_cmd_valid, o_icb_cmd_addr, c_icb_cmd_ready, a_icb_cmd_ready, busy, AA); end
      @(negedge clk);
    end
    o_icb_cmd_ready = 1'b1;
    #1;
    n_cmp++; if (a_icb_cmd_ready !== 1'b1 || c_icb_cmd_ready !== 1'b0 || o_icb_cmd_addr !== AA) begin
      n_err++; $display("FAIL hold_release got ar=%b cr=%b addr=%h exp 1/0/%h", a_icb_cmd_ready, c_icb_cmd_ready, o_icb_cmd_addr, AA); end
    @(negedge clk);
    a_icb_cmd_valid = 1'b0; c_icb_cmd_valid = 1'b0; o_icb_cmd_ready = 1'b0; o_icb_rsp_valid = 1'b1;
    #1;
    n_cmp++; if (busy !== 1'b1 || a_icb_rsp_valid !== 1'b1 || c_icb_rsp_valid !== 1'b0) begin
      n_err++; $display("FAIL hold_rsp got busy=%b a=%b c=%b exp 1/1/0", busy, a_icb_rsp_valid, c_icb_rsp_valid); end
    @(negedge clk);
    o_icb_rsp_valid = 1'b0;
  endtask

  task automatic test_full();
    logic exp_c;
    reset_dut();
    c_icb_cmd_valid = 1'b1; o_icb_cmd_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      c_icb_cmd_addr = 32'h4000_0000 + 32'(4 * i);
      #1;
      n_cmp++; if (c_icb_cmd_ready !== 1'b1) begin n_err++; $display("FAIL full_fill cyc=%0d got cr=%b exp=1", i, c_icb_cmd_ready); end
      @(negedge clk);
    end
    a_icb_cmd_valid = 1'b1;
    #1;
    n_cmp++; if (busy !== 1'b1 || c_icb_cmd_ready !== 1'b0 || a_icb_cmd_ready !== 1'b0 || o_icb_cmd_valid !== 1'b0) begin
      n_err++; $display("FAIL full_block got busy=%b cr=%b ar=%b ov=%b exp 1/0/0/0", busy, c_icb_cmd_ready, a_icb_cmd_ready, o_icb_cmd_valid); end
    @(negedge clk);
    o_icb_rsp_valid = 1'b1;
    #1;
    n_cmp++; if (o_icb_rsp_ready !== 1'b1 || c_icb_rsp_valid !== 1'b1 || c_icb_cmd_ready !== 1'b0) begin
      n_err++; $display("FAIL full_pop got ordy=%b cv=%b cr=%b exp 1/1/0", o_icb_rsp_ready, c_icb_rsp_valid, c_icb_cmd_ready); end
    @(negedge clk);
    #1;
    n_cmp++; if (a_icb_cmd_ready !== 1'b1 || o_icb_rsp_ready !== 1'b1) begin
      n_err++; $display("FAIL full_push_pop got ar=%b ordy=%b exp 1/1", a_icb_cmd_ready, o_icb_rsp_ready); end
    @(negedge clk);
    c_icb_cmd_valid = 1'b0; a_icb_cmd_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      exp_c = (i < 2);
      #1;
      n_cmp++; if (c_icb_rsp_valid !== exp_c || a_icb_rsp_valid !== !exp_c) begin
        n_err++; $display("FAIL full_drain idx=%0d got c=%b a=%b exp c=%b", i, c_icb_rsp_valid, a_icb_rsp_valid, exp_c); end
      @(negedge clk);
    end
    o_icb_rsp_valid = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL full_empty_busy got=%b exp=0", busy); end
  endtask

  task automatic test_interleave();
    reset_dut();
    o_icb_cmd_ready = 1'b1;
    c_icb_cmd_valid = 1'b1; c_icb_cmd_addr = 32'h4000_0020;
    @(negedge clk);
    c_icb_cmd_valid = 1'b0;
    a_icb_cmd_valid = 1'b1; a_icb_cmd_read = 1'b0; a_icb_cmd_wdata = 32'hCAFE_F00D; a_icb_cmd_wmask = 4'hF;
    #1;
    n_cmp++; if (o_icb_cmd_read !== 1'b0 || o_icb_cmd_wdata !== 32'hCAFE_F00D || o_icb_cmd_wmask !== 4'hF) begin
      n_err++; $display("FAIL il_write_payload got r=%b d=%h m=%h exp 0/cafef00d/f", o_icb_cmd_read, o_icb_cmd_wdata, o_icb_cmd_wmask); end
    @(negedge clk);
    a_icb_cmd_valid = 1'b0;
    c_icb_cmd_valid = 1'b1; c_icb_cmd_addr = 32'h4000_0030;
    @(negedge clk);
    c_icb_cmd_valid = 1'b0; o_icb_cmd_ready = 1'b0;
    o_icb_rsp_valid = 1'b1; o_icb_rsp_rdata = 32'h1111_1111; o_icb_rsp_err = 1'b0;
    #1;
    n_cmp++; if (c_icb_rsp_valid !== 1'b1 || c_icb_rsp_rdata !== 32'h1111_1111 || a_icb_rsp_valid !== 1'b0) begin
      n_err++; $display("FAIL il_rsp0 got cv=%b d=%h av=%b exp 1/11111111/0", c_icb_rsp_valid, c_icb_rsp_rdata, a_icb_rsp_valid); end
    @(negedge clk);
    a_icb_rsp_ready = 1'b0; o_icb_rsp_rdata = 32'h2222_2222; o_icb_rsp_err = 1'b1;
    #1;
    n_cmp++; if (a_icb_rsp_valid !== 1'b1 || o_icb_rsp_ready !== 1'b0) begin
      n_err++; $display("FAIL il_rsp1_stall got av=%b ordy=%b exp 1/0", a_icb_rsp_valid, o_icb_rsp_ready); end
    @(negedge clk);
    a_icb_rsp_ready = 1'b1;
    #1;
    n_cmp++; if (a_icb_rsp_err !== 1'b1 || c_icb_rsp_err !== 1'b0 || c_icb_rsp_valid !== 1'b0 ||
                 a_icb_rsp_rdata !== 32'h2222_2222 || o_icb_rsp_ready !== 1'b1) begin
      n_err++; $display("FAIL il_rsp1 got aerr=%b cerr=%b cv=%b d=%h ordy=%b exp 1/0/0/22222222/1",
                        a_icb_rsp_err, c_icb_rsp_err, c_icb_rsp_valid, a_icb_rsp_rdata, o_icb_rsp_ready); end
    @(negedge clk);
    o_icb_rsp_rdata = 32'h3333_3333; o_icb_rsp_err = 1'b0;
    #1;
    n_cmp++; if (c_icb_rsp_valid !== 1'b1 || c_icb_rsp_rdata !== 32'h3333_3333 || a_icb_rsp_valid !== 1'b0) begin
      n_err++; $display("FAIL il_rsp2 got cv=%b d=%h av=%b exp 1/33333333/0", c_icb_rsp_valid, c_icb_rsp_rdata, a_icb_rsp_valid); end
    @(negedge clk);
    o_icb_rsp_valid = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL il_empty_busy got=%b exp=0", busy); end
  endtask

  task automatic test_qos();
`ifdef E203_SRAM_ARB_QOS_EN
    int first_acc;
    first_acc = -1;
    reset_dut();
    c_icb_cmd_valid = 1'b1; a_icb_cmd_valid = 1'b1; o_icb_cmd_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      o_icb_rsp_valid = (i > 0);
      #1;
      if (a_icb_cmd_ready === 1'b1 && first_acc < 0) first_acc = i;
      @(negedge clk);
    end
    n_cmp++; if (first_acc !== 16) begin n_err++; $display("FAIL qos_starve got first_acc_cycle=%0d exp=16", first_acc); end
    c_icb_cmd_valid = 1'b0; a_icb_cmd_valid = 1'b0; o_icb_rsp_valid = 1'b1;
    @(negedge clk);
    o_icb_rsp_valid = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL qos_drain_busy got=%b exp=0", busy); end
`endif
  endtask

  task automatic test_reset_mid();
    reset_dut();
    c_icb_cmd_valid = 1'b1; a_icb_cmd_valid = 1'b1; o_icb_cmd_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL rmid_busy_before got=%b exp=1", busy); end
    rst = 1'b1;
    #1;
    n_cmp++; if (busy !== 1'b0 || o_icb_rsp_ready !== 1'b0) begin
      n_err++; $display("FAIL rmid_clear got busy=%b ordy=%b exp 0/0", busy, o_icb_rsp_ready); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b0 || o_icb_cmd_addr !== CA || c_icb_cmd_ready !== 1'b1) begin
      n_err++; $display("FAIL rmid_after got busy=%b addr=%h cr=%b exp 0/%h/1", busy, o_icb_cmd_addr, c_icb_cmd_ready, CA); end
    @(negedge clk);
    c_icb_cmd_valid = 1'b0; a_icb_cmd_valid = 1'b0; o_icb_cmd_ready = 1'b0;
    o_icb_rsp_valid = 1'b1;
    @(negedge clk);
    o_icb_rsp_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_read();
    test_round_robin();
    test_hold();
    test_full();
    test_interleave();
    test_qos();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
